cache_req_dispatch: RTL

Downstream consumer of the cache request queue. It pops the head entry (address, operation, flush flag, source and destination IDs) and presents it to the cache/memory port with a valid/ready handshake. Each issued request gets a rolling tag, and the block bounds the number of requests in flight. Flush entries are serialised: all prior requests drain first, the flush is issued, and its response is awaited before the next pop.

---
 rtl/cache_pkg.sv | 30 +++
 rtl/out_tracker.sv | 39 +++
 rtl/cache_req_dispatch.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared cache request definitions: operation codes, dispatch FSM states
// and default dispatch sizing used by the queue and the dispatcher.
package cache_pkg;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_LOAD  = 3'd1;
    localparam logic [2:0] OP_STORE = 3'd2;
    localparam logic [2:0] OP_AMO   = 3'd3;
    localparam logic [2:0] OP_PREF  = 3'd4;
    localparam logic [2:0] OP_FLUSH = 3'd7;

    localparam int DEF_MAX_OUT = 4;
    localparam int DEF_TAG_W   = 2;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DRAIN,
        FLUSH_WAIT
    } dispatch_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  op;
        logic        flush;
        logic [1:0]  src;
        logic [1:0]  dest;
    } cache_req_t;

endpackage

// File: rtl/out_tracker.sv
// In-flight request bookkeeping: outstanding count, rolling issue tag
// and a sticky flag for responses arriving with nothing in flight.
module out_tracker #(
    parameter int MAX_OUT = 4,
    parameter int TAG_W   = 2,
    parameter int CNT_W   = $clog2(MAX_OUT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue,
    input  logic             rsp,
    output logic [CNT_W-1:0] outstanding,
    output logic [TAG_W-1:0] tag_ctr,
    output logic             err_underflow
);

    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding   <= '0;
            tag_ctr       <= '0;
            err_underflow <= 1'b0;
        end else begin
            if (issue) begin
                tag_ctr <= tag_ctr + TAG_W'(1);
            end
            // issue and response in the same cycle cancel out
            if (issue && !rsp) begin
                outstanding <= outstanding + CNT_W'(1);
            end else if (!issue && rsp) begin
                if (outstanding == '0) begin
                    err_underflow <= 1'b1;
                end else begin
                    outstanding <= outstanding - CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/cache_req_dispatch.sv
// Pops the cache request queue and issues tagged requests with a credit limit.
// Optional DISPATCH_STATS_EN adds saturating issue/stall counters.
module cache_req_dispatch
    import cache_pkg::*;
#(
    parameter int MAX_OUT = DEF_MAX_OUT,
    parameter int TAG_W   = DEF_TAG_W,
    localparam int CNT_W  = $clog2(MAX_OUT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             q_valid,
    input  logic [31:0]      q_addr,
    input  logic [2:0]       q_op,
    input  logic             q_is_flush,
    input  logic [1:0]       q_src,
    input  logic [1:0]       q_dest,
    output logic             q_dealloc,
    output logic             req_valid,
    input  logic             req_ready,
    output logic [31:0]      req_addr,
    output logic [2:0]       req_op,
    output logic             req_flush,
    output logic [1:0]       req_src,
    output logic [1:0]       req_dest,
    output logic [TAG_W-1:0] req_tag,
    input  logic             rsp_valid,
    input  logic [TAG_W-1:0] rsp_tag,
    output logic [CNT_W-1:0] outstanding,
    output logic             busy,
`ifdef DISPATCH_STATS_EN
    output logic [31:0]      stat_issued,
    output logic [31:0]      stat_stall,
`endif
    output logic             err_underflow
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

    dispatch_state_t  state;
    dispatch_state_t  state_nxt;
    cache_req_t       stage;
    cache_req_t       head;
    logic             flush_pending;
    logic [TAG_W-1:0] flush_tag;
    logic [TAG_W-1:0] tag_ctr;
    logic             issue;
    logic             flush_done;

    assign head = '{
        addr:  q_addr,
        op:    q_op,
        flush: q_is_flush,
        src:   q_src,
        dest:  q_dest
    };

    assign issue      = req_valid && req_ready;
    assign flush_done = (state == FLUSH_WAIT) && rsp_valid
                        && (rsp_tag == flush_tag);

    always_comb begin
        state_nxt = state;
        q_dealloc = 1'b0;
        req_valid = 1'b0;
        unique case (state)
            IDLE: begin
                if (q_valid && q_is_flush) begin
                    state_nxt = DRAIN;
                end else if (q_valid && (outstanding < MAX_CNT)) begin
                    q_dealloc = 1'b1;
                    state_nxt = SEND;
                end
            end
            DRAIN: begin
                if (q_valid && (outstanding == '0)) begin
                    q_dealloc = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                req_valid = 1'b1;
                if (req_ready) begin
                    state_nxt = flush_pending ? FLUSH_WAIT : IDLE;
                end
            end
            FLUSH_WAIT: begin
                if (flush_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            stage         <= '0;
            flush_pending <= 1'b0;
            flush_tag     <= '0;
        end else begin
            state <= state_nxt;
            if (q_dealloc) begin
                stage <= head;
            end
            if (q_dealloc && (state == DRAIN)) begin
                flush_pending <= 1'b1;
            end else if (flush_done) begin
                flush_pending <= 1'b0;
            end
            // the flush is the only request in flight, so its tag is fixed
            if (issue && flush_pending) begin
                flush_tag <= tag_ctr;
            end
        end
    end

    out_tracker #(
        .MAX_OUT (MAX_OUT),
        .TAG_W   (TAG_W),
        .CNT_W   (CNT_W)
    ) u_out_tracker (
        .clk           (clk),
        .rst           (rst),
        .issue         (issue),
        .rsp           (rsp_valid),
        .outstanding   (outstanding),
        .tag_ctr       (tag_ctr),
        .err_underflow (err_underflow)
    );

    assign req_addr  = stage.addr;
    assign req_op    = stage.op;
    assign req_flush = stage.flush;
    assign req_src   = stage.src;
    assign req_dest  = stage.dest;
    assign req_tag   = tag_ctr;
    assign busy      = (state != IDLE) || (outstanding != '0);

`ifdef DISPATCH_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_issued <= '0;
            stat_stall  <= '0;
        end else begin
            if (issue && (stat_issued != '1)) begin
                stat_issued <= stat_issued + 32'd1;
            end
            if (q_valid && !q_dealloc && (stat_stall != '1)) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule
